// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings for the load/store path
package mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1
    } lsu_state_t;

endpackage

// File: rtl/byte_lane_merge.sv
// rtl/byte_lane_merge.sv - big-endian lane extract/extend for loads and lane insert for stores
module byte_lane_merge
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [1:0]  offset,
    input  logic [31:0] rd_word,
    input  logic [15:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merge_word
);

    // Offset 0 is the most significant lane, so the shift counts down from the top.
    logic [4:0]  byte_shift;
    logic [4:0]  half_shift;
    logic [31:0] byte_sel;
    logic [31:0] half_sel;

    assign byte_shift = {~offset, 3'b000};
    assign half_shift = {~offset[1], 4'b0000};
    assign byte_sel   = rd_word >> byte_shift;
    assign half_sel   = rd_word >> half_shift;

    always_comb begin
        load_data  = rd_word;
        merge_word = rd_word;
        case (size)
            SIZE_BYTE: begin
                load_data  = {{24{sign_ext & byte_sel[7]}}, byte_sel[7:0]};
                merge_word = (rd_word & ~(32'h0000_00FF << byte_shift))
                           | ({24'h0, store_data[7:0]} << byte_shift);
            end
            SIZE_HALF: begin
                load_data  = {{16{sign_ext & half_sel[15]}}, half_sel[15:0]};
                merge_word = (rd_word & ~(32'h0000_FFFF << half_shift))
                           | ({16'h0, store_data} << half_shift);
            end
            default: begin
                load_data  = rd_word;
                merge_word = rd_word;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - sub-word load/store adapter with read-modify-write for SB/SH
module load_store_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              MemReadM,
    input  logic              MemWriteM,
    input  logic [1:0]        SizeM,
    input  logic              SignedM,
    input  logic [ADDR_W-1:0] ALUOutM,
    input  logic [DATA_W-1:0] WriteDataM,
    output logic [ADDR_W-1:0] MemA,
    output logic [DATA_W-1:0] MemWD,
    output logic              MemWE,
    input  logic [DATA_W-1:0] MemRD,
    output logic [DATA_W-1:0] LoadDataM,
    output logic              StallM,
    output logic              MisalignM
);

    lsu_state_t        state, next_state;
    logic [DATA_W-1:0] merge_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] aligned_addr;
    logic [DATA_W-1:0] lane_load;
    logic [DATA_W-1:0] lane_merge;
    logic              misaligned;
    logic              sub_word;
    logic              request;

    assign aligned_addr = ALUOutM & ADDR_W'(ALIGN_MASK);
    assign request      = MemReadM | MemWriteM;
    assign sub_word     = (SizeM == SIZE_BYTE) || (SizeM == SIZE_HALF);

    always_comb begin
        case (SizeM)
            SIZE_BYTE: misaligned = 1'b0;
            SIZE_HALF: misaligned = ALUOutM[0];
            default:   misaligned = (ALUOutM[1:0] != 2'b00);
        endcase
    end

    byte_lane_merge u_lane (
        .size       (SizeM),
        .sign_ext   (SignedM),
        .offset     (ALUOutM[1:0]),
        .rd_word    (MemRD),
        .store_data (WriteDataM[15:0]),
        .load_data  (lane_load),
        .merge_word (lane_merge)
    );

    // Outputs are also gated by RESET so an asserted reset kills MemWE without waiting for a clock.
    always_comb begin
        next_state = state;
        MemA       = aligned_addr;
        MemWD      = WriteDataM;
        MemWE      = 1'b0;
        StallM     = 1'b0;
        MisalignM  = 1'b0;
        LoadDataM  = '0;
        case (state)
            IDLE: begin
                if (!RESET) begin
                    if (request && misaligned) begin
                        MisalignM = 1'b1;
                    end else if (MemReadM) begin
                        LoadDataM = lane_load;
                    end else if (MemWriteM) begin
                        if (sub_word) begin
                            StallM     = 1'b1;
                            next_state = WRITE;
                        end else begin
                            MemWE = 1'b1;
                        end
                    end
                end
            end
            WRITE: begin
                MemA       = addr_q;
                MemWD      = merge_q;
                MemWE      = !RESET;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= IDLE;
            merge_q <= '0;
            addr_q  <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && next_state == WRITE) begin
                merge_q <= lane_merge;
                addr_q  <= aligned_addr;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        MemReadM, MemWriteM, SignedM;
    logic [1:0]  SizeM;
    logic [31:0] ALUOutM, WriteDataM;
    logic [31:0] MemA, MemWD, MemRD, LoadDataM;
    logic        MemWE, StallM, MisalignM;

    logic [31:0] mem [0:15];
    logic        preload_en = 1'b0;
    logic [31:0] preload_val = 32'h0;

    int errors = 0;
    int checks = 0;

    load_store_unit dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .SizeM      (SizeM),
        .SignedM    (SignedM),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .MemA       (MemA),
        .MemWD      (MemWD),
        .MemWE      (MemWE),
        .MemRD      (MemRD),
        .LoadDataM  (LoadDataM),
        .StallM     (StallM),
        .MisalignM  (MisalignM)
    );

    always #5 CLK = ~CLK;

    assign MemRD = mem[MemA[5:2]];

    always @(negedge CLK) begin
        if (preload_en)
            mem[4] <= preload_val;
        else if (MemWE)
            mem[MemA[5:2]] <= MemWD;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic sg, input logic [31:0] a, input logic [31:0] wd);
        MemReadM   = rd;
        MemWriteM  = wr;
        SizeM      = sz;
        SignedM    = sg;
        ALUOutM    = a;
        WriteDataM = wd;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 2'd2, 1'b0, 32'h0040_0010, 32'h0);
    endtask

    task automatic preload(input logic [31:0] v);
        idle();
        preload_val = v;
        preload_en  = 1'b1;
        step();
        preload_en  = 1'b0;
    endtask

    initial begin
        int idx, cyc, stalls;
        logic [31:0] b2b_addr [0:1];
        logic [31:0] b2b_data [0:1];
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        RESET = 1'b1;
        drive(1'b0, 1'b1, 2'd0, 1'b0, 32'h0040_0011, 32'hAB);
        step();
        #2;
        check_eq("rst_we",       {31'h0, MemWE},     32'h0);
        check_eq("rst_stall",    {31'h0, StallM},    32'h0);
        check_eq("rst_misalign", {31'h0, MisalignM}, 32'h0);
        check_eq("rst_load",     LoadDataM,          32'h0);
        step();
        RESET = 1'b0;

        preload(32'h1122_33F4);
        drive(1'b1, 1'b0, 2'd0, 1'b1, 32'h0040_0011, 32'h0); #2;
        check_eq("lb_off1", LoadDataM, 32'h0000_0022);
        check_eq("lb_mema", MemA,      32'h0040_0010);
        check_eq("lb_stall", {31'h0, StallM}, 32'h0);
        step();
        drive(1'b1, 1'b0, 2'd0, 1'b1, 32'h0040_0013, 32'h0); #2;
        check_eq("lb_off3", LoadDataM, 32'hFFFF_FFF4);
        step();
        drive(1'b1, 1'b0, 2'd0, 1'b0, 32'h0040_0013, 32'h0); #2;
        check_eq("lbu_off3", LoadDataM, 32'h0000_00F4);
        check_eq("lbu_stall", {31'h0, StallM}, 32'h0);
        step();

        preload(32'h1122_8344);
        drive(1'b1, 1'b0, 2'd1, 1'b1, 32'h0040_0012, 32'h0); #2;
        check_eq("lh_off2", LoadDataM, 32'hFFFF_8344);
        step();
        drive(1'b1, 1'b0, 2'd1, 1'b0, 32'h0040_0012, 32'h0); #2;
        check_eq("lhu_off2", LoadDataM, 32'h0000_8344);
        step();
        drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h0040_0010, 32'h0); #2;
        check_eq("lw", LoadDataM, 32'h1122_8344);
        step();
        drive(1'b1, 1'b0, 2'd3, 1'b0, 32'h0040_0010, 32'h0); #2;
        check_eq("lw_size3", LoadDataM, 32'h1122_8344);
        step();

        preload(32'h1122_3344);
        drive(1'b0, 1'b1, 2'd0, 1'b0, 32'h0040_0011, 32'h0000_00AB); #2;
        check_eq("sb_c0_stall", {31'h0, StallM}, 32'h1);
        check_eq("sb_c0_we",    {31'h0, MemWE},  32'h0);
        step(); #2;
        check_eq("sb_c1_we",    {31'h0, MemWE},  32'h1);
        check_eq("sb_c1_mema",  MemA,            32'h0040_0010);
        check_eq("sb_c1_memwd", MemWD,           32'h11AB_3344);
        check_eq("sb_c1_stall", {31'h0, StallM}, 32'h0);
        step();
        drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h0040_0010, 32'h0); #2;
        check_eq("sb_then_lw", LoadDataM, 32'h11AB_3344);
        step();

        preload(32'h1122_3344);
        drive(1'b0, 1'b1, 2'd1, 1'b0, 32'h0040_0011, 32'h0000_BEEF); #2;
        check_eq("sh_mis_flag",  {31'h0, MisalignM}, 32'h1);
        check_eq("sh_mis_stall", {31'h0, StallM},    32'h0);
        check_eq("sh_mis_we",    {31'h0, MemWE},     32'h0);
        step();
        drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h0040_0012, 32'h0); #2;
        check_eq("sh_mis_we2",  {31'h0, MemWE},  32'h0);
        check_eq("sh_mis_word", mem[4],          32'h1122_3344);
        check_eq("lw_mis_flag", {31'h0, MisalignM}, 32'h1);
        check_eq("lw_mis_load", LoadDataM,       32'h0);
        step();

        drive(1'b0, 1'b1, 2'd1, 1'b0, 32'h0040_0012, 32'h0000_BEEF); #2;
        check_eq("rstw_c0_stall", {31'h0, StallM}, 32'h1);
        step(); #1;
        check_eq("rstw_we_pre", {31'h0, MemWE}, 32'h1);
        RESET = 1'b1;
        #1;
        check_eq("rstw_we_drop", {31'h0, MemWE}, 32'h0);
        idle();
        #5;
        RESET = 1'b0;
        #1;
        check_eq("rstw_stall_after", {31'h0, StallM}, 32'h0);
        check_eq("rstw_we_after",    {31'h0, MemWE},  32'h0);
        step();
        check_eq("rstw_word", mem[4], 32'h1122_3344);

        b2b_addr[0] = 32'h0040_0010; b2b_data[0] = 32'h0000_0001;
        b2b_addr[1] = 32'h0040_0013; b2b_data[1] = 32'h0000_0002;
        idx = 0; cyc = 0; stalls = 0;
        while (idx < 2 && cyc < 10) begin
            drive(1'b0, 1'b1, 2'd0, 1'b0, b2b_addr[idx], b2b_data[idx]);
            #2;
            if (StallM) stalls++;
            else idx++;
            cyc++;
            step();
        end
        idle();
        check_eq("b2b_cycles", 32'(cyc),    32'd4);
        check_eq("b2b_stalls", 32'(stalls), 32'd2);
        check_eq("b2b_word",   mem[4],      32'h0122_3302);
        drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h0040_0010, 32'h0); #2;
        check_eq("b2b_lw", LoadDataM, 32'h0122_3302);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
